dmem_responder: RTL and testbench

Responder end of the MIPS core's data-memory port. It accepts the core's load/store requests (address from the ALU, store data, write strobe) and returns load data. It adds a request/ready handshake with a configurable number of wait states, so the pipeline can be exercised against slow memory. Storage is an internal word-addressed RAM.

---
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS core: word-addressed RAM behind a request/ready handshake with WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned byte addresses into error responses.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_t            state, stateNext;
  logic [3:0]        waitCnt, waitCntNext;
  logic              accept, commit;
  logic              reqWe;
  logic [31:0]       reqAddr, reqWdata;
  logic              cmdWe;
  logic [31:0]       cmdAddr, cmdWdata;
  logic [ADDR_W-1:0] wordIdx;
  logic              outOfRange, addrErr;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];

  // Next-state logic; an accepted request overrides whatever IDLE/RESP would do.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    accept      = 1'b0;
    case (state)
      IDLE: accept = mem_en;
      WAIT: begin
        if (waitCnt <= 4'd1) begin
          stateNext   = RESP;
          waitCntNext = 4'd0;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESP: begin
        accept    = mem_en;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (accept) begin
      stateNext   = (WAIT_CYCLES > 0) ? WAIT : RESP;
      waitCntNext = WaitLoad;
    end
  end

  // With no wait states the access commits on the accepting edge, so use the live request.
  assign cmdWe    = (state == WAIT) ? reqWe    : mem_we;
  assign cmdAddr  = (state == WAIT) ? reqAddr  : mem_addr;
  assign cmdWdata = (state == WAIT) ? reqWdata : mem_wdata;
  assign commit   = (stateNext == RESP);
  assign wordIdx  = cmdAddr[ADDR_W+1:2];

  assign outOfRange = (cmdAddr >> (ADDR_W + 2)) != 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign addrErr = outOfRange || (cmdAddr[1:0] != 2'b00);
`else
  assign addrErr = outOfRange;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      reqWe     <= 1'b0;
      reqAddr   <= 32'd0;
      reqWdata  <= 32'd0;
      mem_rdata <= 32'd0;
      mem_err   <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      mem_err <= commit && addrErr;
      if (accept) begin
        reqWe    <= mem_we;
        reqAddr  <= mem_addr;
        reqWdata <= mem_wdata;
      end
      if (commit) begin
        if (addrErr) begin
          mem_rdata <= 32'd0;
        end else if (!cmdWe) begin
          mem_rdata <= ram[wordIdx];
        end
      end
    end
  end

  // RAM is deliberately not reset; the rst gate only blocks a commit decoded during reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && cmdWe && !addrErr) begin
      ram[wordIdx] <= cmdWdata;
    end
  end

  assign mem_ready = (state == RESP);
  assign busy      = (state == WAIT) || ((state == RESP) && !mem_en);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a zero-wait instance driven from a vector table
// and a three-wait-state instance driven by hand-written latency and reset sequences.
module tb_dmem_responder;

  typedef struct {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expReady;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk;
  logic        rst0, en0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;
  logic        rst3, en3, we3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        ready3, err3, busy3;

  int   assertCount = 0;
  int   failCount   = 0;
  vec_t vecs [22];

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .mem_en(en0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0), .mem_err(err0),
    .busy(busy0)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .mem_en(en3), .mem_we(we3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(rdata3), .mem_ready(ready3), .mem_err(err3),
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One table row on the zero-wait instance: drive at negedge, sample at the following negedge.
  task automatic applyStimulus(input vec_t v, input int idx);
    en0    = v.en;
    we0    = v.we;
    addr0  = v.addr;
    wdata0 = v.wdata;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("row%0d ready", idx), {31'd0, ready0}, {31'd0, v.expReady});
    if (v.expReady) checkOutput($sformatf("row%0d err", idx), {31'd0, err0}, {31'd0, v.expErr});
    checkOutput($sformatf("row%0d rdata", idx), rdata0, v.expRdata);
    checkOutput($sformatf("row%0d busy", idx), {31'd0, busy0}, 32'd0);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue3(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    en3    = 1'b1;
    we3    = we;
    addr3  = addr;
    wdata3 = wdata;
    step();
    en3 = 1'b0;
  endtask

  task automatic waitReady3(input string name);
    int n = 0;
    while (!ready3 && n < 20) begin
      step();
      n++;
    end
    checkOutput({name, " ready"}, {31'd0, ready3}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h0,    32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'h2000, 32'h11111111, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 1'b1, 32'h0};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[7]  = '{1'b1, 1'b1, 32'h13,   32'h12345678, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFC,  32'hCAFEF00D, 1'b1, 1'b0, 32'hDEADBEEF};
`else
    vecs[7]  = '{1'b1, 1'b1, 32'h13,   32'h12345678, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFC,  32'hCAFEF00D, 1'b1, 1'b0, 32'h12345678};
`endif
    vecs[10] = '{1'b1, 1'b0, 32'hFFC,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'hA5A5A5A5};
    vecs[13] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};
    for (int k = 0; k < 4; k++) begin
      vecs[14+2*k] = '{1'b1, 1'b1, 32'h40, 32'(k + 1), 1'b1, 1'b0,
                       (k == 0) ? 32'hA5A5A5A5 : 32'(k)};
      vecs[15+2*k] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'(k + 1)};
    end

    rst0 = 1'b1; en0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    rst3 = 1'b1; en3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
    step();
    step();
    rst0 = 1'b0;
    rst3 = 1'b0;
    step();
    checkOutput("reset0 rdata", rdata0, 32'h0);
    checkOutput("reset0 ready", {31'd0, ready0}, 32'd0);
    checkOutput("reset0 err",   {31'd0, err0},   32'd0);
    checkOutput("reset0 busy",  {31'd0, busy0},  32'd0);
    checkOutput("reset3 ready", {31'd0, ready3}, 32'd0);
    checkOutput("reset3 busy",  {31'd0, busy3},  32'd0);

    for (int i = 0; i < 22; i++) applyStimulus(vecs[i], i);
    en0 = 1'b0;
    step();
    checkOutput("stream end ready", {31'd0, ready0}, 32'd0);

    // Seed a word, then check exact load latency and that mem_en during WAIT is ignored.
    issue3(1'b1, 32'h8, 32'h0BADCAFE);
    waitReady3("w3 seed store");
    checkOutput("w3 seed err", {31'd0, err3}, 32'd0);
    step();
    en3 = 1'b1; we3 = 1'b0; addr3 = 32'h8;
    step();
    en3 = 1'b0;
    checkOutput("lat c1 busy",  {31'd0, busy3},  32'd1);
    checkOutput("lat c1 ready", {31'd0, ready3}, 32'd0);
    step();
    checkOutput("lat c2 busy",  {31'd0, busy3},  32'd1);
    checkOutput("lat c2 ready", {31'd0, ready3}, 32'd0);
    en3 = 1'b1; we3 = 1'b1; addr3 = 32'h8; wdata3 = 32'hFFFFFFFF;
    step();
    en3 = 1'b0;
    checkOutput("lat c3 busy",  {31'd0, busy3},  32'd1);
    checkOutput("lat c3 ready", {31'd0, ready3}, 32'd0);
    step();
    checkOutput("lat c4 ready", {31'd0, ready3}, 32'd1);
    checkOutput("lat c4 err",   {31'd0, err3},   32'd0);
    checkOutput("lat c4 rdata", rdata3, 32'h0BADCAFE);
    checkOutput("lat c4 busy",  {31'd0, busy3},  32'd1);
    step();
    checkOutput("lat c5 ready", {31'd0, ready3}, 32'd0);
    checkOutput("lat c5 busy",  {31'd0, busy3},  32'd0);
    issue3(1'b0, 32'h8, 32'h0);
    waitReady3("w3 reload");
    checkOutput("w3 reload rdata", rdata3, 32'h0BADCAFE);
    step();

    // Reset while a store sits in WAIT: outputs clear at once and the store is lost.
    issue3(1'b1, 32'h20, 32'h01020304);
    waitReady3("rst prestore");
    step();
    issue3(1'b0, 32'h20, 32'h0);
    waitReady3("rst preload");
    checkOutput("rst preload rdata", rdata3, 32'h01020304);
    step();
    issue3(1'b1, 32'h20, 32'h55AA55AA);
    checkOutput("rst wait busy", {31'd0, busy3}, 32'd1);
    #2 rst3 = 1'b1;
    #1;
    checkOutput("rst async busy",  {31'd0, busy3},  32'd0);
    checkOutput("rst async ready", {31'd0, ready3}, 32'd0);
    checkOutput("rst async err",   {31'd0, err3},   32'd0);
    checkOutput("rst async rdata", rdata3, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    step();
    issue3(1'b0, 32'h20, 32'h0);
    waitReady3("rst postload");
    checkOutput("rst postload rdata", rdata3, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
